// File: rtl/alu_exec_unit_if.sv
// Handshake bundle between register-read and the execute ALU.
// master drives op/ctrl/flush; slave returns ready/result/flags.
interface alu_exec_unit_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        alu_ctrl;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              flush;
  logic              out_valid;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              err;
`ifdef ALU_MUL_HI_EN
  logic [DATA_W-1:0] result_hi;

  modport master (
    output in_valid, alu_ctrl, op_a, op_b, flush,
    input  in_ready, out_valid, result, zero, err,
    input  result_hi
  );

  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, flush,
    output in_ready, out_valid, result, zero, err,
    output result_hi
  );
`else
  modport master (
    output in_valid, alu_ctrl, op_a, op_b, flush,
    input  in_ready, out_valid, result, zero, err
  );

  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, flush,
    output in_ready, out_valid, result, zero, err
  );
`endif
endinterface

// File: rtl/alu_exec_unit.sv
// Execute ALU: 1-cycle add/sub/and/or/shl, DATA_W-cycle shift-add mul.
// Ports: clk, rst_n (async low), bus (slave). ALU_MUL_HI_EN adds result_hi.
module alu_exec_unit #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_exec_unit_if.slave bus
);

`ifdef ALU_MUL_HI_EN
  localparam int AW = 2 * DATA_W;
`else
  localparam int AW = DATA_W;
`endif

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]     acc;
  logic [AW-1:0]     acc_nxt;
  logic [AW-1:0]     mcand;
  logic [DATA_W-1:0] mplier;
  logic [CNT_W-1:0]  cnt;
  logic              last;
  logic              accept;
  logic              is_mul;
  logic [DATA_W-1:0] simple_res;
  logic              illegal;

  logic              out_valid_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;
  logic              err_q;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.err       = err_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign is_mul = (bus.alu_ctrl == 3'b101);
  assign last   = (cnt == CNT_W'(DATA_W - 1));

  // Iteration add folded in so the final add lands in the result.
  assign acc_nxt = mplier[0] ? acc + mcand : acc;

  always_comb begin
    simple_res = '0;
    illegal    = 1'b0;
    case (bus.alu_ctrl)
      3'b000: simple_res = bus.op_a + bus.op_b;
      3'b001: simple_res = bus.op_a - bus.op_b;
      3'b010: simple_res = bus.op_a & bus.op_b;
      3'b011: simple_res = bus.op_a | bus.op_b;
      3'b100: simple_res = bus.op_a << bus.op_b[3:0];
      3'b101: simple_res = '0;
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept && is_mul) state_nxt = MUL;
      MUL:  if (bus.flush || last) state_nxt = IDLE;
    endcase
  end

`ifdef ALU_MUL_HI_EN
  logic [DATA_W-1:0] result_hi_q;
  assign bus.result_hi = result_hi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_hi_q <= '0;
    end else if (state == IDLE) begin
      if (accept && !is_mul) result_hi_q <= '0;
    end else if (!bus.flush && last) begin
      result_hi_q <= acc_nxt[AW-1:DATA_W];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      cnt         <= '0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              mcand  <= AW'(bus.op_a);
              mplier <= bus.op_b;
              acc    <= '0;
              cnt    <= '0;
            end else begin
              result_q    <= simple_res;
              zero_q      <= (simple_res == '0);
              err_q       <= illegal;
              out_valid_q <= 1'b1;
            end
          end
        end
        MUL: begin
          // Flush drops the mul; visible outputs keep the last completion.
          if (!bus.flush) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
              result_q    <= acc_nxt[DATA_W-1:0];
              zero_q      <= (acc_nxt[DATA_W-1:0] == '0);
              err_q       <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table plus mul/flush/reset runs.
// Prints one summary line with error and check counts.
module tb_alu_exec_unit;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  alu_exec_unit_if #(.DATA_W(16)) bus ();

  alu_exec_unit #(.DATA_W(16), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ctrl;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        z;
    logic        e;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [2:0] c,
                        input logic [15:0] a, input logic [15:0] b);
    bus.in_valid = v;
    bus.alu_ctrl = c;
    bus.op_a     = a;
    bus.op_b     = b;
  endtask

  // Issue a mul, then count edges to its out_valid.
  // If hold_add, an add 1+1 waits on in_valid during the mul.
  task automatic do_mul(input string name, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp,
                        input logic hold_add);
    int  cyc;
    bit  got;
    bit  rdy_bad;
    @(negedge clk);
    set_in(1'b1, 3'b101, a, b);
    @(posedge clk); #1;
    chk({name, "_ready_low"}, 32'(bus.in_ready), 32'd0);
    chk({name, "_no_early_valid"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    if (hold_add) set_in(1'b1, 3'b000, 16'h0001, 16'h0001);
    else          set_in(1'b0, 3'b000, 16'h0000, 16'h0000);
    cyc = 0;
    got = 1'b0;
    rdy_bad = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.out_valid) got = 1'b1;
      else if (bus.in_ready) rdy_bad = 1'b1;
    end
    chk({name, "_done"}, 32'(got), 32'd1);
    chk({name, "_latency"}, 32'(cyc), 32'd16);
    chk({name, "_ready_held_low"}, 32'(rdy_bad), 32'd0);
    chk({name, "_result"}, 32'(bus.result), 32'(exp));
    chk({name, "_zero"}, 32'(bus.zero), 32'(exp == 16'h0));
    chk({name, "_err"}, 32'(bus.err), 32'd0);
    chk({name, "_ready_in_done"}, 32'(bus.in_ready), 32'd1);
    if (hold_add) begin
      @(posedge clk); #1;
      chk({name, "_held_add_valid"}, 32'(bus.out_valid), 32'd1);
      chk({name, "_held_add_res"}, 32'(bus.result), 32'h2);
      @(negedge clk);
      set_in(1'b0, 3'b000, 16'h0000, 16'h0000);
    end
    @(posedge clk); #1;
    chk({name, "_single_pulse"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int  i;
    int  k;
    bit  seen;
    errors = 0;
    checks = 0;

    vecs[0]  = '{3'b000, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0};
    vecs[1]  = '{3'b001, 16'h0003, 16'h0003, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{3'b011, 16'h00F0, 16'h000F, 16'h00FF, 1'b0, 1'b0};
    vecs[3]  = '{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[4]  = '{3'b100, 16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0};
    vecs[5]  = '{3'b010, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0};
    vecs[6]  = '{3'b001, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
    vecs[7]  = '{3'b110, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b1};
    vecs[8]  = '{3'b010, 16'h00FF, 16'hFFFF, 16'h00FF, 1'b0, 1'b0};
    vecs[9]  = '{3'b111, 16'hABCD, 16'h0001, 16'h0000, 1'b1, 1'b1};
    vecs[10] = '{3'b100, 16'h8001, 16'h0001, 16'h0002, 1'b0, 1'b0};
    vecs[11] = '{3'b011, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};

    rst_n = 1'b0;
    bus.flush = 1'b0;
    set_in(1'b0, 3'b000, 16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Back-to-back: one new op every cycle.
    for (i = 0; i < 12; i++) begin
      @(negedge clk);
      set_in(1'b1, vecs[i].ctrl, vecs[i].a, vecs[i].b);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("vec%0d_result", i), 32'(bus.result),
          32'(vecs[i].res));
      chk($sformatf("vec%0d_zero", i), 32'(bus.zero), 32'(vecs[i].z));
      chk($sformatf("vec%0d_err", i), 32'(bus.err), 32'(vecs[i].e));
    end
    @(negedge clk);
    set_in(1'b0, 3'b000, 16'h0000, 16'h0000);
    @(posedge clk); #1;
    chk("idle_no_valid", 32'(bus.out_valid), 32'd0);

    do_mul("mul_12x34", 16'h0012, 16'h0034, 16'h03A8, 1'b1);
`ifdef ALU_MUL_HI_EN
    chk("hi_after_add", 32'(bus.result_hi), 32'd0);
    do_mul("mul_ffff", 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0);
    chk("mul_ffff_hi", 32'(bus.result_hi), 32'hFFFE);
`endif

    // Flush in IDLE must not block a same-cycle accept.
    @(negedge clk);
    bus.flush = 1'b1;
    set_in(1'b1, 3'b000, 16'h0004, 16'h0004);
    @(posedge clk); #1;
    chk("idle_flush_valid", 32'(bus.out_valid), 32'd1);
    chk("idle_flush_res", 32'(bus.result), 32'h8);
    @(negedge clk);
    bus.flush = 1'b0;

    // Flush at mul iteration 5.
    set_in(1'b1, 3'b101, 16'h0007, 16'h0009);
    @(posedge clk); #1;
    @(negedge clk);
    set_in(1'b0, 3'b000, 16'h0000, 16'h0000);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_idle", 32'(bus.in_ready), 32'd1);
    chk("flush_no_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_res_kept", 32'(bus.result), 32'h8);
    @(negedge clk);
    bus.flush = 1'b0;
    seen = 1'b0;
    for (k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("flush_never_valid", 32'(seen), 32'd0);

    // Reset pulse in the middle of a mul.
    @(negedge clk);
    set_in(1'b1, 3'b101, 16'h0007, 16'h0009);
    @(posedge clk); #1;
    @(negedge clk);
    set_in(1'b0, 3'b000, 16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_result", 32'(bus.result), 32'd0);
    chk("midrst_zero", 32'(bus.zero), 32'd0);
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    set_in(1'b1, 3'b000, 16'h0010, 16'h0020);
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_res", 32'(bus.result), 32'h30);

    do_mul("mul_7x9", 16'h0007, 16'h0009, 16'h003F, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
